// File: rtl/serial_pkg.sv
// Shared UART definitions: receiver FSM states and frame constants.
package serial_pkg;

  typedef enum logic [1:0] {
    s_idle,
    s_start,
    s_data,
    s_stop
  } rx_state_t;

  localparam int UART_WAIT_DIV_DEFAULT = 434;
  localparam int UART_DATA_BITS        = 8;

endpackage

// File: rtl/serial_rx_fifo.sv
// Show-ahead receive FIFO with overrun pulse; simultaneous push/pop allowed when full.
module serial_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             overrun_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign overrun = overrun_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      overrun_q <= push && full && !do_pop;
    end
  end

endmodule

// File: rtl/serial_recv.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, shift register and receive FIFO.
module serial_recv
  import serial_pkg::*;
#(
  parameter int WAIT_DIV   = UART_WAIT_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      data_in,
  input  logic                      RE,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      Empty,
  output logic                      Busy,
  output logic                      Frame_err,
  output logic                      Overrun
);

  localparam int CW = $clog2(WAIT_DIV);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(WAIT_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WAIT_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

  rx_state_t                 state_q, state_d;
  logic                      sync1_q, rx_s_q, rx_p_q;
  logic [CW-1:0]             wait_cnt_q, wait_cnt_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      frame_err_q, frame_err_d;
  logic                      brk_q, brk_d;
  logic                      push, fall, tick_half, tick_bit;

  assign fall      = rx_p_q && !rx_s_q;
  assign tick_half = (wait_cnt_q == HALF_LAST);
  assign tick_bit  = (wait_cnt_q == BIT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
    end else begin
      sync1_q <= data_in;
      rx_s_q  <= sync1_q;
      rx_p_q  <= rx_s_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= s_idle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      s_idle:  if (fall && !brk_q) state_d = s_start;
      s_start: if (tick_half) state_d = rx_s_q ? s_idle : s_data;
      s_data:  if (tick_bit && bit_cnt_q == LAST_BIT) state_d = s_stop;
      s_stop:  if (tick_bit) state_d = s_idle;
      default: state_d = s_idle;
    endcase
  end

  // A framing error arms brk so a held-low line cannot restart the FSM until it goes high.
  always_comb begin
    wait_cnt_d  = wait_cnt_q + CW'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    brk_d       = brk_q && !rx_s_q;
    case (state_q)
      s_idle:  wait_cnt_d = '0;
      s_start: if (tick_half) begin
        wait_cnt_d = '0;
        bit_cnt_d  = '0;
      end
      s_data:  if (tick_bit) begin
        wait_cnt_d = '0;
        shift_d    = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
        bit_cnt_d  = bit_cnt_q + BW'(1);
      end
      s_stop:  if (tick_bit) begin
        wait_cnt_d = '0;
        if (rx_s_q) begin
          push = 1'b1;
        end else begin
          frame_err_d = 1'b1;
          brk_d       = 1'b1;
        end
      end
      default: wait_cnt_d = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_err_q <= frame_err_d;
      brk_q       <= brk_d;
    end
  end

  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
  end

  assign Busy      = (state_q != s_idle);
  assign Frame_err = frame_err_q;

  serial_rx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_data (shift_q),
    .pop       (RE),
    .head      (data_out),
    .empty     (Empty),
    .full      (),
    .overrun   (Overrun)
  );

endmodule
